// File: rtl/control_ascensor.sv
// Four-floor elevator controller: one request at a time, timed travel per floor
// and timed door dwell. Every output comes straight from a register.
module control_ascensor #(
    parameter int T_VIAJE  = 8,
    parameter int T_PUERTA = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pedido_valido,
    input  logic [1:0] pedido_piso,
    output logic       pedido_ack,
    output logic       motor_subir,
    output logic       motor_bajar,
    output logic       puerta_abierta,
    output logic [1:0] piso_actual,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUBIR  = 2'd1,
        BAJAR  = 2'd2,
        PUERTA = 2'd3
    } state_t;

    localparam logic [7:0] CARGA_VIAJE  = 8'(T_VIAJE - 1);
    localparam logic [7:0] CARGA_PUERTA = 8'(T_PUERTA - 1);

    state_t     state_reg;
    logic [7:0] timer_reg;
    logic [1:0] target_reg;
    logic [1:0] piso_next;

    // Floor the car reaches when the current travel slot expires; saturates at the ends.
    always_comb begin
        piso_next = piso_actual;
        if (state_reg == SUBIR && piso_actual != 2'd3) begin
            piso_next = piso_actual + 2'd1;
        end else if (state_reg == BAJAR && piso_actual != 2'd0) begin
            piso_next = piso_actual - 2'd1;
        end
    end

    assign estado = state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= REPOSO;
            timer_reg      <= 8'd0;
            target_reg     <= 2'd0;
            piso_actual    <= 2'd0;
            pedido_ack     <= 1'b0;
            motor_subir    <= 1'b0;
            motor_bajar    <= 1'b0;
            puerta_abierta <= 1'b0;
        end else begin
            pedido_ack <= 1'b0;
            case (state_reg)
                REPOSO: begin
                    if (pedido_valido) begin
                        if (pedido_piso > piso_actual) begin
                            target_reg  <= pedido_piso;
                            timer_reg   <= CARGA_VIAJE;
                            motor_subir <= 1'b1;
                            state_reg   <= SUBIR;
                        end else if (pedido_piso < piso_actual) begin
                            target_reg  <= pedido_piso;
                            timer_reg   <= CARGA_VIAJE;
                            motor_bajar <= 1'b1;
                            state_reg   <= BAJAR;
                        end else begin
                            timer_reg      <= CARGA_PUERTA;
                            puerta_abierta <= 1'b1;
                            pedido_ack     <= 1'b1;
                            state_reg      <= PUERTA;
                        end
                    end
                end
                SUBIR, BAJAR: begin
                    if (timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                    end else begin
                        piso_actual <= piso_next;
                        // An end-of-shaft floor is treated as an arrival so the car can never overrun.
                        if (piso_next == target_reg || piso_next == piso_actual) begin
                            motor_subir    <= 1'b0;
                            motor_bajar    <= 1'b0;
                            puerta_abierta <= 1'b1;
                            pedido_ack     <= 1'b1;
                            timer_reg      <= CARGA_PUERTA;
                            state_reg      <= PUERTA;
                        end else begin
                            timer_reg <= CARGA_VIAJE;
                        end
                    end
                end
                PUERTA: begin
                    if (timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                    end else begin
                        puerta_abierta <= 1'b0;
                        state_reg      <= REPOSO;
                    end
                end
                default: begin
                    state_reg <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_ascensor.sv
// Directed bench for control_ascensor with T_VIAJE=4, T_PUERTA=3, followed by
// random back-to-back traffic with per-cycle invariant checks.
module tb_control_ascensor;

    logic       clk;
    logic       reset;
    logic       pedido_valido;
    logic [1:0] pedido_piso;
    logic       pedido_ack;
    logic       motor_subir;
    logic       motor_bajar;
    logic       puerta_abierta;
    logic [1:0] piso_actual;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    control_ascensor #(
        .T_VIAJE (4),
        .T_PUERTA(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pedido_valido (pedido_valido),
        .pedido_piso   (pedido_piso),
        .pedido_ack    (pedido_ack),
        .motor_subir   (motor_subir),
        .motor_bajar   (motor_bajar),
        .puerta_abierta(puerta_abierta),
        .piso_actual   (piso_actual),
        .estado        (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {pedido_ack, motor_subir, motor_bajar, puerta_abierta, estado, piso_actual};
    endfunction

    function automatic logic [7:0] vec(input logic a, input logic s, input logic b,
                                       input logic d, input logic [1:0] e, input logic [1:0] p);
        return {a, s, b, d, e, p};
    endfunction

    // Travel takes 4 cycles per floor; arrival acks with the door, door stays 3 cycles.
    task automatic trip(input logic [1:0] from, input logic [1:0] to, input bit retarget);
        int         n;
        logic       up;
        logic [1:0] p;
        logic [1:0] st;
        up = (to > from);
        n  = up ? int'(to) - int'(from) : int'(from) - int'(to);
        st = up ? 2'd1 : 2'd2;
        pedido_valido = 1'b1;
        pedido_piso   = to;
        for (int e = 0; e < 4 * n; e++) begin
            tick();
            p = up ? from + 2'(e / 4) : from - 2'(e / 4);
            chk($sformatf("viaje_%0d_%0d_e%0d", from, to, e), outs(), vec(1'b0, up, !up, 1'b0, st, p));
            if (retarget && e == 2) pedido_piso = 2'd1;
        end
        tick();
        chk($sformatf("llegada_%0d", to), outs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, to));
        pedido_valido = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("puerta_%0d_k%0d", to, k), outs(), vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, to));
        end
        tick();
        chk($sformatf("reposo_%0d", to), outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, to));
    endtask

    initial begin
        int         acks;
        int         issued;
        int         guard;
        logic       prev_ack;
        logic [1:0] prev_piso;
        logic       salto_ok;

        reset         = 1'b1;
        pedido_valido = 1'b0;
        pedido_piso   = 2'd0;
        tick();
        tick();
        chk("reset", outs(), 8'h00);
        reset = 1'b0;
        tick();
        chk("reposo_inicial", outs(), 8'h00);

        // Same-floor request held past its ack is served a second time.
        pedido_valido = 1'b1;
        pedido_piso   = 2'd0;
        tick();
        chk("mismo_piso_ack1", outs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0));
        tick();
        chk("mismo_piso_puerta_a", outs(), vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0));
        tick();
        chk("mismo_piso_puerta_b", outs(), vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0));
        tick();
        chk("mismo_piso_reposo", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        chk("mismo_piso_ack2", outs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0));
        pedido_valido = 1'b0;
        tick();
        tick();
        tick();
        chk("mismo_piso_fin", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));

        trip(2'd0, 2'd2, 1'b0);
        trip(2'd2, 2'd0, 1'b0);
        trip(2'd0, 2'd1, 1'b0);

        pedido_valido = 1'b1;
        pedido_piso   = 2'd1;
        tick();
        chk("piso1_ack", outs(), vec(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1));
        pedido_valido = 1'b0;
        tick();
        chk("piso1_puerta_a", outs(), vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1));
        tick();
        chk("piso1_puerta_b", outs(), vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1));
        tick();
        chk("piso1_reposo", outs(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1));

        trip(2'd1, 2'd0, 1'b0);
        trip(2'd0, 2'd3, 1'b1);
        trip(2'd3, 2'd1, 1'b0);

        // Reset in the third SUBIR cycle of a 1->3 trip.
        pedido_valido = 1'b1;
        pedido_piso   = 2'd3;
        tick();
        chk("reset_viaje_subir", outs(), vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("reset_en_viaje", outs(), 8'h00);
        reset         = 1'b0;
        pedido_valido = 1'b0;
        tick();
        chk("reset_en_viaje_reposo", outs(), 8'h00);

        // Random traffic: invariants every cycle, one ack per issued request.
        acks      = 0;
        issued    = 0;
        prev_ack  = 1'b0;
        prev_piso = piso_actual;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!pedido_valido && $urandom_range(0, 2) == 0) begin
                pedido_valido = 1'b1;
                pedido_piso   = 2'($urandom_range(0, 3));
                issued++;
            end
            tick();
            chk("inv_motores", {31'd0, motor_subir & motor_bajar}, 32'd0);
            chk("inv_puerta_motor", {31'd0, (motor_subir | motor_bajar) & puerta_abierta}, 32'd0);
            chk("inv_ack_doble", {31'd0, pedido_ack & prev_ack}, 32'd0);
            salto_ok = (piso_actual == prev_piso)
                    || (prev_piso != 2'd3 && piso_actual == prev_piso + 2'd1)
                    || (prev_piso != 2'd0 && piso_actual == prev_piso - 2'd1);
            chk("inv_salto_piso", {31'd0, salto_ok}, 32'd1);
            if (pedido_ack) begin
                acks++;
                pedido_valido = 1'b0;
            end
            prev_ack  = pedido_ack;
            prev_piso = piso_actual;
        end
        guard = 0;
        while (pedido_valido && guard < 200) begin
            tick();
            if (pedido_ack) begin
                acks++;
                pedido_valido = 1'b0;
            end
            guard++;
        end
        chk("drenaje_acotado", {31'd0, pedido_valido}, 32'd0);
        chk("acks_vs_pedidos", 32'(acks), 32'(issued));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
